// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register: PC sequencing, branch
// redirect with wrong-path squash, freeze hold and memory-wait bubbles.
module if_stage_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [INST_W-1:0] if_id_inst,
    output logic              if_id_valid,
    output logic              fetch_stall
);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        CANCEL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] if_id_pc_q;
    logic [INST_W-1:0] if_id_inst_q;
    logic              if_id_valid_q;

    assign pc_inc_d = pc_q + STEP;

    // CANCEL drops the request for one cycle so a memory still working on the
    // wrong-path address abandons it.
    assign imem_req    = (state_q == FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign fetch_stall = imem_req && !imem_ready;

    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
        end else if (freeze) begin
            state_q       <= state_q;
            pc_q          <= pc_q;
            if_id_pc_q    <= if_id_pc_q;
            if_id_inst_q  <= if_id_inst_q;
            if_id_valid_q <= if_id_valid_q;
        end else if (br_taken) begin
            pc_q          <= br_addr;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
            if (state_q == FETCH && !imem_ready) begin
                state_q <= CANCEL;
            end else begin
                state_q <= FETCH;
            end
        end else if (state_q == CANCEL) begin
            state_q       <= FETCH;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
        end else if (imem_ready) begin
            state_q       <= FETCH;
            pc_q          <= pc_inc_d;
            if_id_pc_q    <= pc_inc_d;
            if_id_inst_q  <= imem_rdata;
            if_id_valid_q <= 1'b1;
        end else begin
            state_q       <= FETCH;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: directed scenarios then random traffic,
// checked against a transaction-level reference model.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        fetch_stall;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } ifid_t;

    ifid_t       exp_q[$];
    ifid_t       m_ifid;
    logic [31:0] m_pc;
    bit          m_pc_known = 0;
    bit          m_squash = 0;   // memory access must be skipped next cycle
    bit          done = 0;

    if_stage_fetch #(
        .ADDR_W  (32),
        .INST_W  (32),
        .PC_STEP (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .if_id_pc   (if_id_pc),
        .if_id_inst (if_id_inst),
        .if_id_valid(if_id_valid),
        .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic cyc(input bit r, input bit f, input bit b,
                       input logic [31:0] ba, input bit rdy);
        bit exp_req;
        @(negedge clk);
        rst        = r;
        freeze     = f;
        br_taken   = b;
        br_addr    = ba;
        imem_ready = rdy;
        imem_rdata = m_pc ^ 32'hA5A5_0000;
        #1;
        exp_req = !r && !m_squash;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check("fetch_stall", {31'b0, fetch_stall}, {31'b0, exp_req && !rdy});
        if (m_pc_known) check("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        if (r) begin
            m_pc       = 32'h0;
            m_pc_known = 1;
            m_squash   = 0;
            m_ifid     = '0;
        end else if (!f) begin
            if (b) begin
                m_squash = !m_squash && !rdy;
                m_pc     = ba;
                m_ifid   = '0;
            end else if (m_squash) begin
                m_squash = 0;
                m_ifid   = '0;
            end else if (rdy) begin
                m_ifid = '{valid: 1'b1, pc: m_pc + 32'd4, inst: m_pc ^ 32'hA5A5_0000};
                m_pc   = m_pc + 32'd4;
            end else begin
                m_ifid = '0;
            end
        end
        exp_q.push_back(m_ifid);
    endtask

    // Monitor: compares the registered IF/ID outputs after every edge.
    initial begin
        ifid_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
                check("if_id_pc", if_id_pc, e.pc);
                check("if_id_inst", if_id_inst, e.inst);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ba;
        int unsigned p;
        // reset, then straight-line fetches 0,4,8
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // taken branch to 0x100 with ready high: plain redirect
        cyc(0, 0, 1, 32'h100, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // freeze three cycles, branch pulsed mid-freeze must be ignored
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 1, 32'h200, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // memory wait two cycles
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        // branch during a pending access -> CANCEL, second branch inside CANCEL
        cyc(0, 0, 1, 32'h40, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h80, 0);
        cyc(0, 0, 1, 32'h93, 1);
        cyc(0, 0, 0, 0, 1);
        // wrap at top of address space, then reset mid-access
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            p  = $urandom_range(0, 99);
            ba = (p < 20) ? 32'hFFFF_FFF8 : $urandom;
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 12), ba, ($urandom_range(0, 99) < 70));
        end
        @(negedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
